// File: rtl/digit_serial_addsub_if.sv
`default_nettype none
// ============================================================================
// digit_serial_addsub_if : operand/result bundle for digit_serial_addsub
// Rev 1.0
// ============================================================================
interface digit_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, sub, a, b, ci,
    output busy, done, s, co, ovf
  );
endinterface
`default_nettype wire

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// digit_serial_addsub : multi-cycle add/sub, DIGIT bits per clock
// Rev 1.0
// ============================================================================
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_addsub_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
    $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] res_now;

  // Ripple slice over the low digit of the shifting operands.
  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign dsum[i] = a_q[i] ^ b_q[i] ^ c[i];
    assign c[i+1]  = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
  end

  // Partial result fills from the MSB side; on the last digit the slice sum
  // completes it, so only WIDTH-DIGIT bits ever need storing.
  if (DIGIT < WIDTH) begin : g_multi
    logic [WIDTH-DIGIT-1:0] res_q, res_d;
    assign res_now = {dsum, res_q};
    always_comb begin
      res_d = res_q;
      if (state_q == RUN) res_d = res_now[WIDTH-1:DIGIT];
    end
    always_ff @(posedge clk) begin
      if (!rst_n) res_q <= '0;
      else        res_q <= res_d;
    end
  end else begin : g_single
    assign res_now = dsum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.ci ^ bus.sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          s_d     = res_now;
          co_d    = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// tb_digit_serial_addsub : directed + swept checks of digit_serial_addsub
// Rev 1.0
// ============================================================================
module tb_digit_serial_addsub;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  digit_serial_addsub_if #(.WIDTH(16)) bus0 ();
  digit_serial_addsub_if #(.WIDTH(16)) bus1 ();
  digit_serial_addsub_if #(.WIDTH(16)) bus2 ();
  digit_serial_addsub_if #(.WIDTH(8))  bus3 ();

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  digit_serial_addsub #(.WIDTH(8),  .DIGIT(2))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, co, s} for a w-bit operation using integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic sb,
                                        input logic [15:0] av, input logic [15:0] bv,
                                        input logic cv);
    longint mask, half, x, y, full, sa, sy, r;
    logic [17:0] res;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (!sb) full = x + y + longint'(cv);
    else     full = x + ((~y) & mask) + (cv ? 0 : 1);
    sa = (x >= half) ? x - 2 * half : x;
    sy = (y >= half) ? y - 2 * half : y;
    r  = sb ? (sa - sy - longint'(cv)) : (sa + sy + longint'(cv));
    res[15:0] = 16'(full & mask);
    res[16]   = ((full >> w) & 1) != 0;
    res[17]   = (r >= half) || (r < -half);
    return res;
  endfunction

  task automatic run_op(input logic sb, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, output logic [15:0] rs, output logic rco,
                        output logic rov, output int lat);
    bus0.sub = sb; bus0.a = av; bus0.b = bv; bus0.ci = cv; bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    lat = -1; rs = '0; rco = 1'b0; rov = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus0.done) begin
        lat = i; rs = bus0.s; rco = bus0.co; rov = bus0.ovf;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks += 5;
    if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
    if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus0.done); end
    if (bus0.s !== 16'h0000) begin errors++; $display("FAIL reset_s: got %h want 0000", bus0.s); end
    if (bus0.co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b want 0", bus0.co); end
    if (bus0.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus0.ovf); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_timing();
    bus0.sub = 1'b0; bus0.a = 16'h1234; bus0.b = 16'h0FCD; bus0.ci = 1'b0; bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.s !== 16'h0000) begin
        errors++;
        $display("FAIL basic_run cyc%0d: busy=%b done=%b s=%h want busy=1 done=0 s=0000",
                 j, bus0.busy, bus0.done, bus0.s);
      end
      step();
    end
    checks++;
    if (bus0.done !== 1'b1 || bus0.s !== 16'h2201 || bus0.co !== 1'b0 || bus0.ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b s=%h co=%b ovf=%b want 1 2201 0 0",
               bus0.done, bus0.s, bus0.co, bus0.ovf);
    end
    step();
    checks++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.s !== 16'h2201) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b s=%h want 0 0 2201", bus0.done, bus0.busy, bus0.s);
    end
  endtask

  task automatic test_carry_wrap();
    logic [15:0] rs; logic rco, rov; int lat;
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, rs, rco, rov, lat);
    checks++;
    if (lat !== 4 || rs !== 16'h0000 || rco !== 1'b1 || rov !== 1'b0) begin
      errors++;
      $display("FAIL wrap_b1: lat=%0d s=%h co=%b ovf=%b want 4 0000 1 0", lat, rs, rco, rov);
    end
    run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, rs, rco, rov, lat);
    checks++;
    if (lat !== 4 || rs !== 16'h0000 || rco !== 1'b1 || rov !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ci: lat=%0d s=%h co=%b ovf=%b want 4 0000 1 0", lat, rs, rco, rov);
    end
  endtask

  task automatic test_overflow_sub();
    logic [15:0] rs; logic rco, rov; int lat;
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, rs, rco, rov, lat);
    checks++;
    if (lat !== 4 || rs !== 16'h8000 || rco !== 1'b0 || rov !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf: lat=%0d s=%h co=%b ovf=%b want 4 8000 0 1", lat, rs, rco, rov);
    end
    run_op(1'b1, 16'h0005, 16'h0007, 1'b0, rs, rco, rov, lat);
    checks++;
    if (lat !== 4 || rs !== 16'hFFFE || rco !== 1'b0 || rov !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: lat=%0d s=%h co=%b ovf=%b want 4 fffe 0 0", lat, rs, rco, rov);
    end
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0, rs, rco, rov, lat);
    checks++;
    if (lat !== 4 || rs !== 16'h7FFF || rco !== 1'b1 || rov !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: lat=%0d s=%h co=%b ovf=%b want 4 7fff 1 1", lat, rs, rco, rov);
    end
    run_op(1'b1, 16'h1000, 16'h0001, 1'b1, rs, rco, rov, lat);
    checks++;
    if (lat !== 4 || rs !== 16'h0FFE || rco !== 1'b1 || rov !== 1'b0) begin
      errors++;
      $display("FAIL sub_bin: lat=%0d s=%h co=%b ovf=%b want 4 0ffe 1 0", lat, rs, rco, rov);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    logic exp_done;
    dones = 0;
    bus0.sub = 1'b0; bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.ci = 1'b0; bus0.start = 1'b1;
    step();
    bus0.a = 16'h0100; bus0.b = 16'h0022;
    for (int j = 1; j <= 10; j++) begin
      step();
      exp_done = (j == 4) || (j == 10);
      if (bus0.done) dones++;
      checks++;
      if (bus0.done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done cyc%0d: got %b want %b", j, bus0.done, exp_done);
      end
      if (j == 4) begin
        checks++;
        if (bus0.s !== 16'h3333) begin errors++; $display("FAIL b2b_first: got %h want 3333", bus0.s); end
      end
      if (j == 10) begin
        checks++;
        if (bus0.s !== 16'h0122) begin errors++; $display("FAIL b2b_second: got %h want 0122", bus0.s); end
        bus0.start = 1'b0;
      end
    end
    for (int j = 0; j < 8; j++) begin
      step();
      if (bus0.done) dones++;
    end
    checks++;
    if (dones !== 2) begin errors++; $display("FAIL b2b_count: got %0d dones want 2", dones); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rs; logic rco, rov; int lat;
    int dones;
    bus0.sub = 1'b0; bus0.a = 16'hFFFF; bus0.b = 16'h0001; bus0.ci = 1'b0; bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.s !== 16'h0000 ||
        bus0.co !== 1'b0 || bus0.ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b s=%h co=%b ovf=%b want all 0",
               bus0.busy, bus0.done, bus0.s, bus0.co, bus0.ovf);
    end
    dones = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (bus0.done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d dones want 0", dones); end
    run_op(1'b0, 16'h00FF, 16'h0F01, 1'b1, rs, rco, rov, lat);
    checks++;
    if (lat !== 4 || rs !== 16'h1001 || rco !== 1'b0 || rov !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: lat=%0d s=%h co=%b ovf=%b want 4 1001 0 0", lat, rs, rco, rov);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] ra, rb;
    logic        rsb, rc;
    int          lat1, lat2, lat3;
    logic [17:0] got1, got2, got3, exp1, exp2, exp3;
    for (int v = 0; v < 200; v++) begin
      ra = 16'($urandom); rb = 16'($urandom); rsb = 1'($urandom); rc = 1'($urandom);
      bus1.a = ra; bus1.b = rb; bus1.sub = rsb; bus1.ci = rc; bus1.start = 1'b1;
      bus2.a = ra; bus2.b = rb; bus2.sub = rsb; bus2.ci = rc; bus2.start = 1'b1;
      bus3.a = ra[7:0]; bus3.b = rb[7:0]; bus3.sub = rsb; bus3.ci = rc; bus3.start = 1'b1;
      step();
      bus1.start = 1'b0; bus2.start = 1'b0; bus3.start = 1'b0;
      lat1 = -1; lat2 = -1; lat3 = -1;
      got1 = '0; got2 = '0; got3 = '0;
      for (int cyc = 1; cyc <= 18; cyc++) begin
        step();
        if (bus1.done && lat1 < 0) begin lat1 = cyc; got1 = {bus1.ovf, bus1.co, bus1.s}; end
        if (bus2.done && lat2 < 0) begin lat2 = cyc; got2 = {bus2.ovf, bus2.co, bus2.s}; end
        if (bus3.done && lat3 < 0) begin lat3 = cyc; got3 = {bus3.ovf, bus3.co, 8'h00, bus3.s}; end
      end
      exp1 = model(16, rsb, ra, rb, rc);
      exp2 = exp1;
      exp3 = model(8, rsb, {8'h00, ra[7:0]}, {8'h00, rb[7:0]}, rc);
      checks += 6;
      if (lat1 !== 16) begin errors++; $display("FAIL sweep16x1_lat v%0d: got %0d want 16", v, lat1); end
      if (lat2 !== 1)  begin errors++; $display("FAIL sweep16x16_lat v%0d: got %0d want 1", v, lat2); end
      if (lat3 !== 4)  begin errors++; $display("FAIL sweep8x2_lat v%0d: got %0d want 4", v, lat3); end
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL sweep16x1 v%0d a=%h b=%h sub=%b ci=%b: got %h want %h", v, ra, rb, rsb, rc, got1, exp1);
      end
      if (got2 !== exp2) begin
        errors++;
        $display("FAIL sweep16x16 v%0d a=%h b=%h sub=%b ci=%b: got %h want %h", v, ra, rb, rsb, rc, got2, exp2);
      end
      if (got3 !== exp3) begin
        errors++;
        $display("FAIL sweep8x2 v%0d a=%h b=%h sub=%b ci=%b: got %h want %h",
                 v, ra[7:0], rb[7:0], rsb, rc, got3, exp3);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus0.start = 1'b0; bus0.sub = 1'b0; bus0.a = '0; bus0.b = '0; bus0.ci = 1'b0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
    bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0; bus2.ci = 1'b0;
    bus3.start = 1'b0; bus3.sub = 1'b0; bus3.a = '0; bus3.b = '0; bus3.ci = 1'b0;
    test_reset();
    test_basic_timing();
    test_carry_wrap();
    test_overflow_sub();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
